alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Parametrised execute-stage ALU for the MIPS pipeline.
- Decodes {ALUOp, funct} internally, computes the result, and registers it with a valid/ready handshake.
- Adds an iterative multiply/divide unit (MULT/MULTU/DIV/DIVU) with HI/LO registers and MFHI/MFLO.
- Sits between the ID/EX register and EX/MEM. in_ready drives the hazard unit's EX stall.

Parameters:
- WIDTH, 32, datapath width in bits. Must be ≥ 8 and even.
- SHW, 5, shift-amount width. Must satisfy 2**SHW == WIDTH.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of the accepted/in-flight op
- in_valid  in  1  operation present
- in_ready  out  1  unit can accept an operation this cycle
- alu_op  in  4  main-decoder ALUOp
- funct  in  6  R-type funct field
- shamt  in  SHW  shift amount
- src_a  in  WIDTH  operand A (rs)
- src_b  in  WIDTH  operand B (rt or immediate)
- out_valid  out  1  one-cycle pulse: result/flags valid
- result  out  WIDTH  registered result
- ovf  out  1  signed overflow (ADD/SUB only)
- illegal  out  1  undefined alu_op/funct combination
- mdu_busy  out  1  multiply/divide in progress

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, out_valid=0, result=0, ovf=0, illegal=0, mdu_busy=0, HI=LO=0, counter=0.
  - An in-flight MDU op is discarded.
- Handshake:
  - in_ready = (state==IDLE).
  - An op is accepted when in_valid & in_ready.
- alu_op decode:
  - 0001 EQU: result = (A==B).
  - 0011 NEQ: result = (A!=B).
  - 0100 ADD, 0101 AND, 0110 ADDU, 0111 SLT, 1000 OR.
  - 0010: decode funct as below.
  - 0000 or any other alu_op: illegal=1.
- funct decode (alu_op=0010):
  - 000000 SLL, 000010 SRL, 000011 SRA: operate on B by shamt.
  - 100000 ADD, 100001 ADDU, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT, 101011 SLTU.
  - 010000 MFHI, 010010 MFLO.
  - 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
  - Any other funct: illegal=1.
- Single-cycle ops (incl. MFHI/MFLO, illegal):
  - Latency 1. out_valid=1 on the next edge with result, ovf and illegal.
  - State stays IDLE, so back-to-back issue is allowed.
  - illegal: result=0.
  - EQU/NEQ/SLT/SLTU: result is zero-extended to WIDTH, LSB only.
- Arithmetic:
  - All ops wrap modulo 2**WIDTH.
  - ovf is set only for ADD/SUB signed overflow; result is still written.
  - ADDU, SUB variants other than ADD/SUB, and all other ops: ovf=0.
- MDU ops:
  - Accept → state MUL or DIV. mdu_busy=1, in_ready=0, counter=WIDTH.
  - Each cycle: shift-add (multiply) or restoring subtract (divide) one bit; counter decrements.
  - Counter reaching 0 → HI/LO written, out_valid pulses with result=LO, state→IDLE. Total latency WIDTH+1 cycles.
  - Signed MULT/DIV: operate on magnitudes, then fix signs.
  - Divide: quotient→LO, remainder→HI; remainder takes the dividend's sign.
  - Divide by zero: LO = all ones, HI = dividend. No trap.
  - MIN/−1 signed: LO=MIN, HI=0.
  - Multiply: HI:LO = full 2·WIDTH product.
- MFHI/MFLO directly after an MDU op: in_ready holds the issue until IDLE, so the read returns the new HI/LO.
- flush:
  - Clears out_valid on the next edge.
  - Returns MUL/DIV to IDLE; HI/LO keep their old values.
  - flush & in_valid in the same cycle: the op is not accepted.
- out_valid is low in every cycle that does not complete an op.

Optional Feature:
- ALU_MDU_EN defined: MDU, HI/LO, MFHI/MFLO and the MUL/DIV states are implemented as above.
- ALU_MDU_EN undefined:
  - The MDU funct codes and MFHI/MFLO decode as illegal.
  - mdu_busy is tied 0 and in_ready is tied 1.
  - No HI/LO storage.

Test Plan:
- Reset: rst_n low mid-DIV (counter=10) → mdu_busy=0, in_ready=1, HI=LO=0, out_valid=0 immediately, without waiting for a clock edge.
- ADD/SLT (WIDTH=32):
  - ADD, 0x7FFFFFFF+1 → next cycle result=0x80000000, ovf=1.
  - ADDU, same operands → ovf=0.
  - SLT −1<1 → 1; SLTU same operands → 0.
- SRA: B=0xF0000000, shamt=4 → result 0xFF000000; back-to-back SLL shamt=31 of B=1 → 0x80000000 on the next cycle.
- MULT/MFHI: MULT −3×7 → in_ready=0 for 32 cycles, out_valid at cycle 33, then MFHI=0xFFFFFFFF, MFLO=0xFFFFFFEB.
- DIV:
  - DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 5/0 → LO=0xFFFFFFFF, HI=5.
- Decode/flush: alu_op=0010 funct=111111 → illegal=1, result=0. flush during MUL at counter=5 → IDLE next cycle, HI/LO unchanged, no out_valid. Rebuild without ALU_MDU_EN → MULT reports illegal=1.

Source files
------------

// File: rtl/alu_exec_if.sv
// Operand/result handshake bundle between the ID/EX register and the execute-stage ALU.
interface alu_exec_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic [5:0]       funct;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             illegal;
  logic             mdu_busy;

  modport master (
    output in_valid, alu_op, funct, shamt, src_a, src_b,
    input  in_ready, out_valid, result, ovf, illegal, mdu_busy
  );

  modport slave (
    input  in_valid, alu_op, funct, shamt, src_a, src_b,
    output in_ready, out_valid, result, ovf, illegal, mdu_busy
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decodes {alu_op, funct}, registers result/flags behind a valid/ready handshake.
// Define ALU_MDU_EN to build the iterative MULT/DIV unit with HI/LO and MFHI/MFLO.
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  alu_exec_if.slave bus
);
  logic [WIDTH-1:0] a, b, sum, diff, alu_res, result_q, result_d;
  logic add_ovf, sub_ovf, alu_ovf, dec_ill, accept, in_ready;
  logic out_valid_q, out_valid_d, ovf_q, ovf_d, illegal_q, illegal_d;

  assign a       = bus.src_a;
  assign b       = bus.src_b;
  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

`ifdef ALU_MDU_EN
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;
  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d, step, prod;
  logic [WIDTH-1:0] mag_b_q, mag_b_d, hi_q, hi_d, lo_q, lo_d, mag_a, mag_b;
  logic [WIDTH:0] mul_sum, div_shl, div_try;
  logic neg_q, neg_d, neg_rem_q, neg_rem_d, dec_mul, dec_div, dec_sgn, sign_a, sign_b;

  assign in_ready     = (state_q == StIdle);
  assign bus.mdu_busy = (state_q != StIdle);
  assign sign_a       = dec_sgn & a[WIDTH-1];
  assign sign_b       = dec_sgn & b[WIDTH-1];
  assign mag_a        = sign_a ? -a : a;
  assign mag_b        = sign_b ? -b : b;
`else
  assign in_ready     = 1'b1;
  assign bus.mdu_busy = 1'b0;
`endif

  assign bus.in_ready  = in_ready;
  assign accept        = bus.in_valid && in_ready && !flush;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;
  assign bus.illegal   = illegal_q;

  // Illegal encodings leave alu_res at zero so the registered result reads 0.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    dec_ill = 1'b0;
`ifdef ALU_MDU_EN
    dec_mul = 1'b0;
    dec_div = 1'b0;
    dec_sgn = 1'b0;
`endif
    case (bus.alu_op)
      4'b0001: alu_res = WIDTH'(a == b);
      4'b0011: alu_res = WIDTH'(a != b);
      4'b0100: begin alu_res = sum; alu_ovf = add_ovf; end
      4'b0101: alu_res = a & b;
      4'b0110: alu_res = sum;
      4'b0111: alu_res = WIDTH'($signed(a) < $signed(b));
      4'b1000: alu_res = a | b;
      4'b0010: begin
        case (bus.funct)
          6'b000000: alu_res = b << bus.shamt;
          6'b000010: alu_res = b >> bus.shamt;
          6'b000011: alu_res = WIDTH'($signed(b) >>> bus.shamt);
          6'b100000: begin alu_res = sum; alu_ovf = add_ovf; end
          6'b100001: alu_res = sum;
          6'b100010: begin alu_res = diff; alu_ovf = sub_ovf; end
          6'b100100: alu_res = a & b;
          6'b100101: alu_res = a | b;
          6'b100111: alu_res = ~(a | b);
          6'b101010: alu_res = WIDTH'($signed(a) < $signed(b));
          6'b101011: alu_res = WIDTH'(a < b);
`ifdef ALU_MDU_EN
          6'b010000: alu_res = hi_q;
          6'b010010: alu_res = lo_q;
          6'b011000: begin dec_mul = 1'b1; dec_sgn = 1'b1; end
          6'b011001: dec_mul = 1'b1;
          6'b011010: begin dec_div = 1'b1; dec_sgn = 1'b1; end
          6'b011011: dec_div = 1'b1;
`endif
          default:   dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

`ifdef ALU_MDU_EN
  // work_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, mag_b_q} : '0);
    div_shl = work_q[2*WIDTH-1:WIDTH-1];
    div_try = div_shl - {1'b0, mag_b_q};
    if (state_q == StMul) begin
      step = {mul_sum, work_q[WIDTH-1:1]};
    end else if (!div_try[WIDTH]) begin
      step = {div_try[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
    end else begin
      step = {div_shl[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
    end
  end
`endif

  always_comb begin
    out_valid_d = 1'b0;
    result_d    = result_q;
    ovf_d       = ovf_q;
    illegal_d   = illegal_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      ovf_d       = alu_ovf;
      illegal_d   = dec_ill;
    end
`ifdef ALU_MDU_EN
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    mag_b_d   = mag_b_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    prod      = '0;
    if (accept && (dec_mul || dec_div)) begin
      out_valid_d = 1'b0;
      result_d    = result_q;
      ovf_d       = ovf_q;
      illegal_d   = illegal_q;
      state_d     = dec_mul ? StMul : StDiv;
      cnt_d       = CntW'(WIDTH);
      work_d      = {{WIDTH{1'b0}}, mag_a};
      mag_b_d     = mag_b;
      neg_d       = sign_a ^ sign_b;
      neg_rem_d   = sign_a;
    end else if (state_q != StIdle) begin
      if (flush) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        work_d = step;
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d     = StIdle;
          out_valid_d = 1'b1;
          ovf_d       = 1'b0;
          illegal_d   = 1'b0;
          if (state_q == StMul) begin
            prod = neg_q ? -step : step;
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else begin
            // Divide by zero leaves remainder = |dividend|; sign fix restores the dividend.
            hi_d = neg_rem_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
            lo_d = (mag_b_q == '0) ? '1 : (neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0]);
          end
          result_d = lo_d;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
    end
  end

`ifdef ALU_MDU_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      work_q    <= '0;
      mag_b_q   <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      mag_b_q   <= mag_b_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end
`endif
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases plus random ops against a model.
module tb_alu_exec_unit;
  localparam int unsigned W   = 32;
  localparam int unsigned SHW = 5;
`ifdef ALU_MDU_EN
  localparam bit MduEn = 1'b1;
`else
  localparam bit MduEn = 1'b0;
`endif
  localparam logic [9:0] RndOps [25] = '{
    {4'd1, 6'd0}, {4'd3, 6'd0}, {4'd4, 6'd0}, {4'd5, 6'd0}, {4'd6, 6'd0},
    {4'd7, 6'd0}, {4'd8, 6'd0}, {4'd0, 6'd0}, {4'd2, 6'd0}, {4'd2, 6'd2},
    {4'd2, 6'd3}, {4'd2, 6'd32}, {4'd2, 6'd33}, {4'd2, 6'd34}, {4'd2, 6'd36},
    {4'd2, 6'd37}, {4'd2, 6'd39}, {4'd2, 6'd42}, {4'd2, 6'd43}, {4'd2, 6'd16},
    {4'd2, 6'd18}, {4'd2, 6'd24}, {4'd2, 6'd25}, {4'd2, 6'd26}, {4'd2, 6'd27}
  };

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int tests = 0;
  int fails = 0;
  logic [W-1:0] m_hi, m_lo;

  alu_exec_if #(.WIDTH(W), .SHW(SHW)) bus ();
  alu_exec_unit #(.WIDTH(W), .SHW(SHW)) dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the instruction definitions, using 64-bit arithmetic.
  task automatic model(input logic [3:0] op, input logic [5:0] fn, input logic [SHW-1:0] sh,
                       input logic [W-1:0] a, input logic [W-1:0] b, output logic [W-1:0] r,
                       output logic o, output logic il, output logic mdu);
    logic signed [63:0] sa, sb, s;
    sa = $signed(a);
    sb = $signed(b);
    s = '0;
    r = '0; o = 1'b0; il = 1'b0; mdu = 1'b0;
    case (op)
      4'd1: r = W'(a == b);
      4'd3: r = W'(a != b);
      4'd4: begin s = sa + sb; r = s[W-1:0]; o = (s != $signed(r)); end
      4'd5: r = a & b;
      4'd6: r = a + b;
      4'd7: r = W'(sa < sb);
      4'd8: r = a | b;
      4'd2: begin
        case (fn)
          6'd0:  r = b << sh;
          6'd2:  r = b >> sh;
          6'd3:  begin s = sb >>> sh; r = s[W-1:0]; end
          6'd32: begin s = sa + sb; r = s[W-1:0]; o = (s != $signed(r)); end
          6'd33: r = a + b;
          6'd34: begin s = sa - sb; r = s[W-1:0]; o = (s != $signed(r)); end
          6'd36: r = a & b;
          6'd37: r = a | b;
          6'd39: r = ~(a | b);
          6'd42: r = W'(sa < sb);
          6'd43: r = W'(a < b);
          6'd16: if (MduEn) r = m_hi; else il = 1'b1;
          6'd18: if (MduEn) r = m_lo; else il = 1'b1;
          6'd24, 6'd25, 6'd26, 6'd27: if (MduEn) mdu = 1'b1; else il = 1'b1;
          default: il = 1'b1;
        endcase
      end
      default: il = 1'b1;
    endcase
    if (il) r = '0;
  endtask

  task automatic mdu_ref(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0] up;
    sa = $signed(a);
    sb = $signed(b);
    case (fn)
      6'd24: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      6'd25: begin up = {32'b0, a} * {32'b0, b}; m_hi = up[63:32]; m_lo = up[31:0]; end
      6'd26: begin
        if (b == '0) begin m_lo = '1; m_hi = a; end
        else begin p = sa / sb; m_lo = p[31:0]; p = sa % sb; m_hi = p[31:0]; end
      end
      6'd27: begin
        if (b == '0) begin m_lo = '1; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      default: ;
    endcase
  endtask

  task automatic drive(input logic [3:0] op, input logic [5:0] fn, input logic [SHW-1:0] sh,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    bus.alu_op   = op;
    bus.funct    = fn;
    bus.shamt    = sh;
    bus.src_a    = a;
    bus.src_b    = b;
    bus.in_valid = 1'b1;
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] r, input logic o,
                           input logic il);
    chk({tag, " out_valid"}, W'(bus.out_valid), W'(1));
    chk({tag, " result"}, bus.result, r);
    chk({tag, " ovf"}, W'(bus.ovf), W'(o));
    chk({tag, " illegal"}, W'(bus.illegal), W'(il));
  endtask

  task automatic run_op(input logic [3:0] op, input logic [5:0] fn, input logic [SHW-1:0] sh,
                        input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] r;
    logic o, il, mdu;
    int busy, done;
    model(op, fn, sh, a, b, r, o, il, mdu);
    @(negedge clk);
    drive(op, fn, sh, a, b);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (!mdu) begin
      check_out(tag, r, o, il);
    end else begin
      mdu_ref(fn, a, b);
      busy = 0;
      done = -1;
      for (int k = 0; k < 40; k++) begin
        if (k > 0) begin
          @(posedge clk);
          #1;
        end
        if (bus.out_valid) begin
          done = k;
          break;
        end
        if (!bus.in_ready) busy++;
      end
      chk({tag, " busy_cycles"}, W'(busy), W'(W));
      chk({tag, " latency"}, W'(done), W'(W));
      check_out(tag, m_lo, 1'b0, 1'b0);
    end
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return W'($urandom_range(0, 9));
      default: return W'($urandom());
    endcase
  endfunction

  initial begin
    logic [W-1:0] r;
    logic o, il, mdu;
    logic [9:0] pick;
    int ov_cnt;
    bus.in_valid = 1'b0;
    bus.alu_op = '0; bus.funct = '0; bus.shamt = '0; bus.src_a = '0; bus.src_b = '0;
    flush = 1'b0;
    rst_n = 1'b0;
    m_hi = '0;
    m_lo = '0;
    #12;
    chk("rst out_valid", W'(bus.out_valid), W'(0));
    chk("rst result", bus.result, '0);
    chk("rst ovf", W'(bus.ovf), W'(0));
    chk("rst illegal", W'(bus.illegal), W'(0));
    chk("rst mdu_busy", W'(bus.mdu_busy), W'(0));
    chk("rst in_ready", W'(bus.in_ready), W'(1));
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd4, 6'd0, 5'd0, 32'h7FFF_FFFF, 32'h1, "add_max");
    chk("add_max lit", bus.result, 32'h8000_0000);
    chk("add_max ovf lit", W'(bus.ovf), W'(1));
    run_op(4'd6, 6'd0, 5'd0, 32'h7FFF_FFFF, 32'h1, "addu_max");
    chk("addu_max ovf lit", W'(bus.ovf), W'(0));
    run_op(4'd2, 6'd34, 5'd0, 32'h8000_0000, 32'h1, "sub_min");
    run_op(4'd2, 6'd42, 5'd0, 32'hFFFF_FFFF, 32'h1, "slt_m1");
    chk("slt lit", bus.result, 32'h1);
    run_op(4'd2, 6'd43, 5'd0, 32'hFFFF_FFFF, 32'h1, "sltu_m1");
    chk("sltu lit", bus.result, 32'h0);
    run_op(4'd1, 6'd0, 5'd0, 32'h1234, 32'h1234, "equ");
    run_op(4'd3, 6'd0, 5'd0, 32'h1234, 32'h1234, "neq");

    // Back-to-back SRA then SLL with no idle cycle between them.
    model(4'd2, 6'd3, 5'd4, 32'h0, 32'hF000_0000, r, o, il, mdu);
    @(negedge clk);
    drive(4'd2, 6'd3, 5'd4, 32'h0, 32'hF000_0000);
    @(posedge clk);
    #1;
    check_out("sra", r, o, il);
    chk("sra lit", bus.result, 32'hFF00_0000);
    model(4'd2, 6'd0, 5'd31, 32'h0, 32'h1, r, o, il, mdu);
    drive(4'd2, 6'd0, 5'd31, 32'h0, 32'h1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_out("sll_b2b", r, o, il);
    chk("sll lit", bus.result, 32'h8000_0000);
    @(posedge clk);
    #1;
    chk("idle out_valid", W'(bus.out_valid), W'(0));

    run_op(4'd2, 6'd63, 5'd0, 32'h5, 32'h6, "funct_bad");
    chk("funct_bad illegal lit", W'(bus.illegal), W'(1));
    run_op(4'd0, 6'd32, 5'd0, 32'h5, 32'h6, "aluop_0");
    run_op(4'd15, 6'd0, 5'd0, 32'h5, 32'h6, "aluop_f");

    run_op(4'd2, 6'd24, 5'd0, 32'hFFFF_FFFD, 32'h7, "mult_m3x7");
    run_op(4'd2, 6'd16, 5'd0, 32'h0, 32'h0, "mfhi_mult");
`ifdef ALU_MDU_EN
    chk("mfhi lit", bus.result, 32'hFFFF_FFFF);
`endif
    run_op(4'd2, 6'd18, 5'd0, 32'h0, 32'h0, "mflo_mult");
`ifdef ALU_MDU_EN
    chk("mflo lit", bus.result, 32'hFFFF_FFEB);
`endif
    run_op(4'd2, 6'd26, 5'd0, 32'hFFFF_FFF9, 32'h2, "div_m7_2");
    run_op(4'd2, 6'd16, 5'd0, 32'h0, 32'h0, "mfhi_div");
    run_op(4'd2, 6'd27, 5'd0, 32'h5, 32'h0, "divu_by0");
    run_op(4'd2, 6'd16, 5'd0, 32'h0, 32'h0, "mfhi_div0");
    run_op(4'd2, 6'd26, 5'd0, 32'hFFFF_FFF9, 32'h0, "div_neg_by0");
    run_op(4'd2, 6'd16, 5'd0, 32'h0, 32'h0, "mfhi_div0s");
    run_op(4'd2, 6'd26, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    run_op(4'd2, 6'd16, 5'd0, 32'h0, 32'h0, "mfhi_minm1");
    run_op(4'd2, 6'd25, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_op(4'd2, 6'd16, 5'd0, 32'h0, 32'h0, "mfhi_multu");

    // flush together with in_valid: the op must not be taken.
    @(negedge clk);
    drive(4'd2, 6'd24, 5'd0, 32'h3, 32'h4);
    flush = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    flush = 1'b0;
    chk("flush_issue out_valid", W'(bus.out_valid), W'(0));
    chk("flush_issue mdu_busy", W'(bus.mdu_busy), W'(0));

`ifdef ALU_MDU_EN
    // flush a multiply when five steps remain; HI/LO must keep the previous values.
    @(negedge clk);
    drive(4'd2, 6'd24, 5'd0, 32'h0001_2345, 32'hFFFF_FF9D);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (27) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_mul mdu_busy", W'(bus.mdu_busy), W'(0));
    chk("flush_mul in_ready", W'(bus.in_ready), W'(1));
    chk("flush_mul out_valid", W'(bus.out_valid), W'(0));
    ov_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) ov_cnt++;
    end
    chk("flush_mul late out_valid", W'(ov_cnt), W'(0));
    run_op(4'd2, 6'd16, 5'd0, 32'h0, 32'h0, "mfhi_flush");
    run_op(4'd2, 6'd18, 5'd0, 32'h0, 32'h0, "mflo_flush");
`endif

    for (int i = 0; i < 60; i++) begin
      pick = RndOps[$urandom_range(0, 24)];
      run_op(pick[9:6], pick[5:0], SHW'($urandom()), rnd_operand(), rnd_operand(), "rnd");
    end

    // Asynchronous reset in the middle of a divide, ten steps before completion.
    run_op(4'd2, 6'd24, 5'd0, 32'h1234_5678, 32'h9ABC_DEF0, "mult_pre_rst");
    @(negedge clk);
    drive(4'd2, 6'd26, 5'd0, 32'h0000_1000, 32'h7);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (22) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst mdu_busy", W'(bus.mdu_busy), W'(0));
    chk("arst in_ready", W'(bus.in_ready), W'(1));
    chk("arst out_valid", W'(bus.out_valid), W'(0));
    chk("arst result", bus.result, '0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'd2, 6'd16, 5'd0, 32'h0, 32'h0, "mfhi_arst");
    run_op(4'd2, 6'd18, 5'd0, 32'h0, 32'h0, "mflo_arst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
